// File: rtl/mole_pkg.sv
// Shared state type and arithmetic helpers for the multi-mole game engine.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } mole_state_t;

    // Concurrent-mole limit for a difficulty: min(diff + 1, max_active).
    function automatic int unsigned active_limit(input logic [1:0] diff,
                                                 input int unsigned max_active);
        int unsigned want;
        want = 32'(diff) + 32'd1;
        return (want < max_active) ? want : max_active;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    // a + plus - minus, clamped to 0..max_val.
    function automatic logic [31:0] sat_net(input logic [31:0] a,
                                            input logic [31:0] plus,
                                            input logic [31:0] minus,
                                            input logic [31:0] max_val);
        logic [32:0] up;
        up = {1'b0, a} + {1'b0, plus};
        if ({1'b0, minus} >= up) begin
            return 32'd0;
        end
        up = up - {1'b0, minus};
        return (up > {1'b0, max_val}) ? max_val : up[31:0];
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole position: occupancy flag plus lifetime countdown in ms ticks.
module mole_slot #(
    parameter int unsigned LIFE_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              tick,
    input  logic              clear,
    input  logic [LIFE_W-1:0] life,
    output logic              active,
    output logic              expired
);

    logic [LIFE_W-1:0] cnt_q;

    // A whack (clear) in the same cycle suppresses the expiry.
    assign expired = active && tick && !clear && (cnt_q == LIFE_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt_q  <= '0;
        end else if (clear) begin
            active <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            active <= 1'b1;
            cnt_q  <= life;
        end else if (expired) begin
            active <= 1'b0;
            cnt_q  <= '0;
        end else if (active && tick) begin
            cnt_q <= cnt_q - LIFE_W'(1);
        end
    end

endmodule

// File: rtl/mole_field_ctrl.sv
// Multi-mole game engine: spawn search, whack scoring, misses and game timer.
// Build option: define MOLE_PENALTY_EN to charge a point for whacking an empty position.
module mole_field_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned N_MOLES     = 18,
    parameter int unsigned MAX_ACTIVE  = 4,
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned LIFE_MS     = 2000,
    parameter int unsigned SPAWN_MS    = 1000,
    parameter int unsigned GAME_S      = 60,
    parameter int unsigned SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         difficulty,
    input  logic [15:0]        random_value,
    input  logic [N_MOLES-1:0] switches,
    output logic [N_MOLES-1:0] mole_leds,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         misses,
    output logic [7:0]         time_left_s,
    output logic               game_active,
    output logic               game_over
);

    localparam int unsigned IDX_W     = $clog2(N_MOLES);
    localparam int unsigned LIFE_W    = $clog2(LIFE_MS + 1);
    localparam int unsigned SPAWN_W   = $clog2(SPAWN_MS + 1);
    localparam int unsigned PS_W      = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int unsigned MS_W      = 10;
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    mole_state_t        state_q, state_d;
    logic [1:0]         diff_q, diff_d;
    logic [PS_W-1:0]    presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic [SPAWN_W-1:0] spawn_q, spawn_d;
    logic [7:0]         time_q, time_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         misses_q, misses_d;
    logic               game_active_q, game_over_q;

    logic [N_MOLES-1:0] sync1_q, sync2_q, prev_q, toggle_q, toggle_d;
    logic [N_MOLES-1:0] occ, load_c, clear_c, expired_c, hits_c;

    logic               play_c, tick_c, sec_c, to_over_c, upd_c, spawn_c, room_c, found_c;
    logic [LIFE_W-1:0]  life_c;
    logic [SPAWN_W-1:0] spawn_lim_c;
    logic [IDX_W-1:0]   cand_c;
    logic [N_MOLES-1:0] rot_c;
    int unsigned        pick_c;

    // Difficulty-scaled lifetime and spawn interval; never below one ms.
    always_comb begin
        life_c = LIFE_W'(LIFE_MS >> diff_q);
        if (life_c == '0) begin
            life_c = LIFE_W'(1);
        end
        spawn_lim_c = SPAWN_W'(SPAWN_MS >> diff_q);
        if (spawn_lim_c == '0) begin
            spawn_lim_c = SPAWN_W'(1);
        end
    end

    // Game timing strobes.
    always_comb begin
        play_c    = (state_q == ST_PLAY) && !start;
        tick_c    = play_c && (presc_q == PS_W'(CLKS_PER_MS - 1));
        sec_c     = tick_c && (ms_q == MS_W'(999));
        to_over_c = sec_c && (time_q == 8'd1);
        upd_c     = play_c && !to_over_c;
        spawn_c   = upd_c && tick_c && (spawn_q == spawn_lim_c - SPAWN_W'(1));
        room_c    = popcount32(32'(occ)) < 6'(active_limit(diff_q, MAX_ACTIVE));
    end

    // First free position at or above the candidate, wrapping; uses registered occupancy.
    always_comb begin
        cand_c  = IDX_W'(random_value % 16'(N_MOLES));
        rot_c   = N_MOLES'({occ, occ} >> cand_c);
        found_c = 1'b0;
        pick_c  = 0;
        for (int i = 0; i < int'(N_MOLES); i++) begin
            if (!found_c && !rot_c[i]) begin
                found_c = 1'b1;
                pick_c  = 32'(cand_c) + 32'(i);
            end
        end
        if (pick_c >= N_MOLES) begin
            pick_c = pick_c - N_MOLES;
        end
        load_c = '0;
        if (spawn_c && room_c && found_c) begin
            load_c = N_MOLES'(1) << pick_c;
        end
    end

    always_comb begin
        hits_c  = upd_c ? (toggle_q & occ) : '0;
        clear_c = {N_MOLES{start || to_over_c}} | hits_c;
    end

    for (genvar g = 0; g < int'(N_MOLES); g++) begin : g_slot
        mole_slot #(
            .LIFE_W(LIFE_W)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .load   (load_c[g]),
            .tick   (tick_c),
            .clear  (clear_c[g]),
            .life   (life_c),
            .active (occ[g]),
            .expired(expired_c[g])
        );
    end

    // Next state and datapath.
    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        presc_d  = presc_q;
        ms_d     = ms_q;
        spawn_d  = spawn_q;
        time_d   = time_q;
        score_d  = score_q;
        misses_d = misses_q;
        toggle_d = (state_q == ST_PLAY) ? (sync2_q ^ prev_q) : '0;

        if (start) begin
            state_d  = ST_PLAY;
            diff_d   = difficulty;
            presc_d  = '0;
            ms_d     = '0;
            spawn_d  = '0;
            time_d   = 8'(GAME_S);
            score_d  = '0;
            misses_d = '0;
        end else if (play_c) begin
            presc_d = tick_c ? '0 : presc_q + PS_W'(1);
            if (tick_c) begin
                ms_d    = (ms_q == MS_W'(999)) ? '0 : ms_q + MS_W'(1);
                spawn_d = (spawn_q == spawn_lim_c - SPAWN_W'(1)) ? '0 : spawn_q + SPAWN_W'(1);
            end
            if (sec_c) begin
                time_d = time_q - 8'd1;
            end
            if (to_over_c) begin
                state_d = ST_OVER;
            end
            if (upd_c) begin
                misses_d = 8'(sat_add(32'(misses_q), 32'(popcount32(32'(expired_c))), 32'd255));
`ifdef MOLE_PENALTY_EN
                score_d = SCORE_W'(sat_net(32'(score_q), 32'(popcount32(32'(hits_c))),
                                           32'(popcount32(32'(toggle_q & ~occ))), SCORE_MAX));
`else
                score_d = SCORE_W'(sat_add(32'(score_q), 32'(popcount32(32'(hits_c))), SCORE_MAX));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            diff_q        <= '0;
            presc_q       <= '0;
            ms_q          <= '0;
            spawn_q       <= '0;
            time_q        <= 8'(GAME_S);
            score_q       <= '0;
            misses_q      <= '0;
            toggle_q      <= '0;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            diff_q        <= diff_d;
            presc_q       <= presc_d;
            ms_q          <= ms_d;
            spawn_q       <= spawn_d;
            time_q        <= time_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            toggle_q      <= toggle_d;
            game_active_q <= (state_d == ST_PLAY);
            game_over_q   <= (state_d == ST_OVER);
        end
    end

    // Switch synchroniser keeps tracking in every state so PLAY starts without a false edge.
    always_ff @(posedge clk) begin
        sync1_q <= switches;
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
    end

    assign mole_leds   = occ;
    assign score       = score_q;
    assign misses      = misses_q;
    assign time_left_s = time_q;
    assign game_active = game_active_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Directed vector bench for mole_field_ctrl (4 positions, 2 ms spawn granularity, 2 s game).
module tb_mole_field_ctrl;

`ifdef MOLE_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  difficulty;
    logic [15:0] random_value;
    logic [3:0]  switches;
    logic [3:0]  mole_leds;
    logic [15:0] score;
    logic [7:0]  misses;
    logic [7:0]  time_left_s;
    logic        game_active;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    mole_field_ctrl #(
        .N_MOLES    (4),
        .MAX_ACTIVE (2),
        .CLKS_PER_MS(2),
        .LIFE_MS    (8),
        .SPAWN_MS   (4),
        .GAME_S     (2),
        .SCORE_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .difficulty  (difficulty),
        .random_value(random_value),
        .switches    (switches),
        .mole_leds   (mole_leds),
        .score       (score),
        .misses      (misses),
        .time_left_s (time_left_s),
        .game_active (game_active),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        logic [1:0]  diff;
        logic [15:0] rnd;
        logic [3:0]  tog;
        int          cycles;
        logic [3:0]  leds;
        int          sc;
        int          ms;
        int          tl;
        bit          act;
        bit          ovr;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Game 1 at difficulty 0: spawn every 8 clk, life 16 clk, limit 1.
        vecs[0]  = '{1'b1, 2'd0, 16'd6, 4'b0000, 1,    4'b0000, 0, 0,   2, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 7,    4'b0000, 0, 0,   2, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 1,    4'b0100, 0, 0,   2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 8,    4'b0100, 0, 0,   2, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 7,    4'b0100, 0, 0,   2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 1,    4'b0000, 0, 1,   2, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 8,    4'b0100, 0, 1,   2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 16'd6, 4'b0100, 3,    4'b0100, 0, 1,   2, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 16'd6, 4'b0000, 1,    4'b0000, 1, 1,   2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 16'd3, 4'b0000, 4,    4'b1000, 1, 1,   2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 16'd3, 4'b0000, 12,   4'b1000, 1, 1,   2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 16'd3, 4'b1000, 4,    4'b0000, 2, 1,   2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 16'd3, 4'b0000, 1943, 4'b1000, 2, 81,  2, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 16'd3, 4'b0000, 1,    4'b0000, 2, 82,  1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 16'd3, 4'b0000, 1999, 4'b0000, 2, 165, 1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 16'd3, 4'b0000, 1,    4'b0000, 2, 165, 0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 2'd0, 16'd3, 4'b1000, 6,    4'b0000, 2, 165, 0, 1'b0, 1'b1};
        // Game 2 at difficulty 1 (input then moved to 3): spawn every 4 clk, life 8 clk, limit 2.
        vecs[17] = '{1'b1, 2'd1, 16'd6, 4'b0000, 1,    4'b0000, 0, 0,   2, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 2'd3, 16'd6, 4'b0000, 4,    4'b0100, 0, 0,   2, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 2'd3, 16'd6, 4'b0000, 4,    4'b1100, 0, 0,   2, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 2'd3, 16'd6, 4'b0000, 3,    4'b1100, 0, 0,   2, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 2'd3, 16'd6, 4'b0000, 1,    4'b1000, 0, 1,   2, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 2'd3, 16'd6, 4'b0000, 4,    4'b0100, 0, 2,   2, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 2'd3, 16'd3, 4'b0000, 4,    4'b1100, 0, 2,   2, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 2'd3, 16'd3, 4'b0000, 4,    4'b1000, 0, 3,   2, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 2'd3, 16'd3, 4'b0000, 4,    4'b0001, 0, 4,   2, 1'b1, 1'b0};
        vecs[26] = '{1'b0, 2'd3, 16'd3, 4'b0000, 4,    4'b1001, 0, 4,   2, 1'b1, 1'b0};
        vecs[27] = '{1'b0, 2'd3, 16'd3, 4'b1001, 3,    4'b1001, 0, 4,   2, 1'b1, 1'b0};
        vecs[28] = '{1'b0, 2'd3, 16'd3, 4'b0000, 1,    4'b0000, 2, 4,   2, 1'b1, 1'b0};
        vecs[29] = '{1'b0, 2'd3, 16'd3, 4'b0010, 4,    4'b1000, 2 - PEN,     4, 2, 1'b1, 1'b0};
        vecs[30] = '{1'b0, 2'd3, 16'd3, 4'b0010, 4,    4'b1001, 2 - 2 * PEN, 4, 2, 1'b1, 1'b0};
        vecs[31] = '{1'b0, 2'd3, 16'd3, 4'b0010, 4,    4'b0001, 2 - 2 * PEN, 5, 2, 1'b1, 1'b0};

        reset        = 1'b1;
        start        = 1'b0;
        difficulty   = 2'd0;
        random_value = 16'd0;
        switches     = 4'b0000;
        step(3);
        check("reset leds", int'(mole_leds), 0);
        check("reset score", int'(score), 0);
        check("reset misses", int'(misses), 0);
        check("reset time", int'(time_left_s), 2);
        check("reset active", int'(game_active), 0);
        check("reset over", int'(game_over), 0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            start        = vecs[i].st;
            difficulty   = vecs[i].diff;
            random_value = vecs[i].rnd;
            switches     = switches ^ vecs[i].tog;
            step(1);
            start = 1'b0;
            if (vecs[i].cycles > 1) begin
                step(vecs[i].cycles - 1);
            end
            check($sformatf("row%0d leds", i), int'(mole_leds), int'(vecs[i].leds));
            check($sformatf("row%0d score", i), int'(score), vecs[i].sc);
            check($sformatf("row%0d misses", i), int'(misses), vecs[i].ms);
            check($sformatf("row%0d time", i), int'(time_left_s), vecs[i].tl);
            check($sformatf("row%0d active", i), int'(game_active), int'(vecs[i].act));
            check($sformatf("row%0d over", i), int'(game_over), int'(vecs[i].ovr));
        end

        // Restart mid-game and time a full game to game_over, bounded.
        start      = 1'b1;
        difficulty = 2'd0;
        step(1);
        start = 1'b0;
        check("restart score", int'(score), 0);
        check("restart time", int'(time_left_s), 2);
        n = 0;
        while (!game_over && n < 5000) begin
            step(1);
            n++;
        end
        check("game length cycles", n, 4000);
        check("end leds", int'(mole_leds), 0);
        check("end time", int'(time_left_s), 0);

        // Synchronous reset from OVER.
        reset = 1'b1;
        step(1);
        check("rst2 over", int'(game_over), 0);
        check("rst2 time", int'(time_left_s), 2);
        check("rst2 misses", int'(misses), 0);
        reset = 1'b0;
        step(2);
        check("idle active", int'(game_active), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
